// File: rtl/gate_op_if.sv
// Request/grant bus between client blocks and the shared gate-op unit,
// plus the valid/ready result channel.
interface gate_op_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] a_in;
  logic [WIDTH*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   res_valid;
  logic [WIDTH-1:0]       res_data;
  logic [ID_W-1:0]        res_id;
  logic                   res_ready;

  modport master (
    output req, op, a_in, b_in, res_ready,
    input  gnt, res_valid, res_data, res_id
  );

  modport slave (
    input  req, op, a_in, b_in, res_ready,
    output gnt, res_valid, res_data, res_id
  );
endinterface

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit among N_REQ clients.
//   state | meaning
//   EMPTY | output register holds no result
//   FULL  | output register holds a result awaiting res_ready
module gate_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input logic        clk,
  input logic        rst_n,
  gate_op_if.slave   bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;

  logic              found;
  logic [ID_W-1:0]   gnt_idx;
  logic              accept;
  logic [2:0]        sel_op;
  logic [WIDTH-1:0]  sel_a, sel_b, result;

  // Search upward from ptr_q, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  assign accept = rst_n && found && ((state_q == EMPTY) || bus.res_ready);

  always_comb begin
    sel_op = bus.op[3*int'(gnt_idx) +: 3];
    sel_a  = bus.a_in[WIDTH*int'(gnt_idx) +: WIDTH];
    sel_b  = bus.b_in[WIDTH*int'(gnt_idx) +: WIDTH];
    case (sel_op)
      3'd0:    result = sel_a & sel_b;
      3'd1:    result = sel_a | sel_b;
      3'd2:    result = ~sel_a;
      3'd3:    result = ~sel_b;
      3'd4:    result = ~(sel_a & sel_b);
      3'd5:    result = ~(sel_a | sel_b);
      3'd6:    result = sel_a ^ sel_b;
      default: result = ~(sel_a ^ sel_b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      default: if (bus.res_ready) state_d = accept ? FULL : EMPTY;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    if (accept) begin
      ptr_d      = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      res_data_d = result;
      res_id_d   = gnt_idx;
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (accept) bus.gnt[gnt_idx] = 1'b1;
    bus.res_valid = (state_q == FULL);
    bus.res_data  = res_data_q;
    bus.res_id    = res_id_q;
  end
endmodule

// File: tb/tb_gate_op_arbiter.sv
// Scoreboard bench for gate_op_arbiter: a bench-side round-robin model predicts
// grants and queues expected results, popped when the output register loads.
module tb_gate_op_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_op_if #(.N_REQ(N), .WIDTH(W), .ID_W(2)) bus ();
  gate_op_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [1:0] id; logic [7:0] data; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] op_t [N];
  logic [7:0] a_t  [N];
  logic [7:0] b_t  [N];

  int         m_ptr = 0;
  bit         m_valid = 0;
  logic [7:0] m_data = 8'h00;
  logic [1:0] m_id = 2'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gate_fn(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case (o)
        3'd0: r[i] = a[i] && b[i];
        3'd1: r[i] = a[i] || b[i];
        3'd2: r[i] = !a[i];
        3'd3: r[i] = !b[i];
        3'd4: r[i] = !(a[i] && b[i]);
        3'd5: r[i] = !(a[i] || b[i]);
        3'd6: r[i] = a[i] != b[i];
        default: r[i] = a[i] == b[i];
      endcase
    end
    return r;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      bus.op[3*i +: 3]   = op_t[i];
      bus.a_in[8*i +: 8] = a_t[i];
      bus.b_in[8*i +: 8] = b_t[i];
    end
  endtask

  // One cycle: drive, check the combinational grant, clock, check the register.
  task automatic step(input logic [3:0] r, input logic rdy);
    int   idx;
    bit   acc;
    logic [3:0] eg;
    exp_t e;
    bus.req = r;
    bus.res_ready = rdy;
    pack_ops();
    #1;
    idx = -1;
    for (int k = 0; k < N; k++)
      if (idx < 0 && r[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
    acc = (idx >= 0) && (!m_valid || rdy);
    eg = 4'b0000;
    if (acc) begin
      eg[idx] = 1'b1;
      e.id = 2'(idx);
      e.data = gate_fn(op_t[idx], a_t[idx], b_t[idx]);
      exp_q.push_back(e);
    end
    check("gnt", 32'(bus.gnt), 32'(eg));
    @(posedge clk);
    #1;
    if (acc) begin
      m_ptr = (idx + 1) % N;
      m_valid = 1;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        m_data = e.data;
        m_id = e.id;
      end
      check("res_valid", 32'(bus.res_valid), 32'd1);
      check("res_data", 32'(bus.res_data), 32'(m_data));
      check("res_id", 32'(bus.res_id), 32'(m_id));
    end else if (m_valid && !rdy) begin
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_data", 32'(bus.res_data), 32'(m_data));
      check("hold_id", 32'(bus.res_id), 32'(m_id));
    end else begin
      m_valid = 0;
      check("res_valid_low", 32'(bus.res_valid), 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_valid = 0;
    m_data = 8'h00;
    m_id = 2'd0;
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin op_t[i] = 3'd0; a_t[i] = 8'h00; b_t[i] = 8'h00; end
    bus.req = 4'b1111;
    bus.res_ready = 1'b1;
    pack_ops();

    // reset with all requests high
    #12;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data", 32'(bus.res_data), 32'd0);
    check("rst_id", 32'(bus.res_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_gnt", 32'(bus.gnt), 32'b0001);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // single XOR
    op_t[0] = 3'd6; a_t[0] = 8'hF0; b_t[0] = 8'h3C;
    step(4'b0001, 1'b1);
    check("xor_literal", 32'(bus.res_data), 32'hCC);
    step(4'b0000, 1'b1);

    // opcode sweep on requester 2
    a_t[2] = 8'hAA; b_t[2] = 8'hCC;
    for (int o = 0; o < 8; o++) begin
      op_t[2] = 3'(o);
      step(4'b0100, 1'b1);
    end
    check("sweep_last", 32'(bus.res_data), 32'h99);
    step(4'b0000, 1'b1);

    // round-robin from reset pointer, then drop req[1]
    rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin op_t[i] = 3'(i + 1); a_t[i] = 8'(8'h11 * (i + 1)); b_t[i] = 8'h5A; end
    for (int c = 0; c < 6; c++) step(4'b1111, 1'b1);
    for (int c = 0; c < 4; c++) step(4'b1101, 1'b1);
    step(4'b0000, 1'b1);

    // backpressure
    op_t[2] = 3'd1; a_t[2] = 8'h0F; b_t[2] = 8'h30;
    step(4'b0100, 1'b1);
    op_t[2] = 3'd7; a_t[2] = 8'h3C; b_t[2] = 8'h0F;
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    // reset between edges with a pending result
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("amid_valid", 32'(bus.res_valid), 32'd0);
    check("amid_data", 32'(bus.res_data), 32'd0);
    check("amid_id", 32'(bus.res_id), 32'd0);
    check("amid_gnt", 32'(bus.gnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // random traffic
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < N; i++) begin
        op_t[i] = 3'($urandom_range(0, 7));
        a_t[i] = 8'($urandom_range(0, 255));
        b_t[i] = 8'($urandom_range(0, 255));
      end
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
